// File: rtl/systema_pio_read_arbiter.sv
// Round-robin read arbiter sharing one systema PIO slave among NUM_REQ requesters.
// Each access walks IDLE -> WAIT -> CAP around the slave's registered read latency.
module systema_pio_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         slv_address,
  input  logic [DATA_W-1:0]         slv_readdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_REQ-1:0] rsp_valid_nxt;
  logic [ADDR_W-1:0]  slv_address_nxt;
  logic [DATA_W-1:0]  rsp_data_nxt;
  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int                 idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      slv_address <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      gnt         <= gnt_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      slv_address <= slv_address_nxt;
    end
  end

  // The owner's request is still high at the capture edge, so it is masked out there.
  always_comb begin
    cand      = (state == CAP) ? (req & ~gnt) : req;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && cand[idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = WAIT;
      WAIT:    state_nxt = CAP;
      CAP:     state_nxt = win_found ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt         = gnt;
    slv_address_nxt = slv_address;
    ptr_nxt         = ptr;
    rsp_valid_nxt   = '0;
    rsp_data_nxt    = rsp_data;
    if (state == CAP) begin
      rsp_valid_nxt = gnt;
      rsp_data_nxt  = slv_readdata;
      gnt_nxt       = '0;
    end
    // A win in CAP chains straight into the next access without passing through IDLE.
    if ((state == IDLE || state == CAP) && win_found) begin
      gnt_nxt          = '0;
      gnt_nxt[win_idx] = 1'b1;
      slv_address_nxt  = req_address[int'(win_idx)*ADDR_W +: ADDR_W];
      ptr_nxt          = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_systema_pio_read_arbiter.sv
// Self-checking bench: vector table plus hand sequences, responses checked against a
// scoreboard of {owner, data, cycle} entries pushed when requests are raised.
module tb_systema_pio_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 32;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] port;
    int          count;
    int          order [4];
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_address = '0;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic [1:0]  slv_address;
  logic [31:0] slv_readdata;
  logic [31:0] in_port = '0;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  hold = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] last_data = '0;
  exp_t        sb [$];
  vec_t        vecs [8];

  systema_pio_read_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_address (req_address),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .slv_address (slv_address),
    .slv_readdata(slv_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PIO input slave: registered readdata, only address 0 returns in_port.
  always @(posedge clk) slv_readdata <= (slv_address == 2'd0) ? in_port : 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int idx, input logic [7:0] addr, input logic [31:0] port, input int c);
    exp_t e;
    e.idx  = idx;
    e.data = (addr[idx*ADDR_W +: ADDR_W] == 2'd0) ? port : 32'd0;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // One cycle: sample at the falling edge, score responses, let requesters drop req.
  task automatic step();
    exp_t e;
    @(negedge clk);
    checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (rsp_valid != 4'd0) begin
      checkOutput("rsp_pulse_width", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_owner", 32'(rsp_valid), 32'(4'b0001 << e.idx));
        checkOutput("rsp_data", rsp_data, e.data);
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
        last_data = e.data;
      end
      req = req & ~(rsp_valid & ~hold);
    end
    prev_valid = (rsp_valid != 4'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int base;
    in_port     = v.port;
    req_address = v.addr;
    base        = cyc;
    for (int j = 0; j < v.count; j++) begin
      pushExp(v.order[j], v.addr, v.port, base + 3 + 2 * j);
    end
    req = req | v.req;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      step();
      n++;
    end
    checkOutput({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
    step();
    step();
    checkOutput({name, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_idle_gnt"}, 32'(gnt), 32'd0);
    checkOutput({name, "_rsp_data_hold"}, rsp_data, last_data);
  endtask

  task automatic setVec(input int i, input logic [3:0] r, input logic [7:0] a, input logic [31:0] p,
                        input int cnt, input int o0, input int o1, input int o2, input int o3);
    vecs[i].req      = r;
    vecs[i].addr     = a;
    vecs[i].port     = p;
    vecs[i].count    = cnt;
    vecs[i].order[0] = o0;
    vecs[i].order[1] = o1;
    vecs[i].order[2] = o2;
    vecs[i].order[3] = o3;
  endtask

  initial begin
    vec_t v;
    int   base;
    int   n;

    // Grant orders follow the round-robin pointer carried from one vector to the next.
    setVec(0, 4'b1111, 8'h00, 32'h1234_5678, 4, 0, 1, 2, 3);
    setVec(1, 4'b0100, 8'h00, 32'h0000_00A5, 1, 2, 0, 0, 0);
    setVec(2, 4'b0010, 8'h08, 32'h0000_00FF, 1, 1, 0, 0, 0);
    setVec(3, 4'b1111, 8'h31, 32'hDEAD_BEEF, 4, 2, 3, 0, 1);
    setVec(4, 4'b1001, 8'h00, 32'h0000_CAFE, 2, 3, 0, 0, 0);
    setVec(5, 4'b0001, 8'h00, 32'h1357_9BDF, 1, 0, 0, 0, 0);
    setVec(6, 4'b1000, 8'h00, 32'h2468_ACE0, 1, 3, 0, 0, 0);
    setVec(7, 4'b1111, 8'h00, 32'h0F0F_0F0F, 4, 0, 1, 2, 3);

    reset = 1'b1;
    step();
    step();
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_slv_address", 32'(slv_address), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      waitDone($sformatf("vec%0d", i));
    end

    // Requester 3 first, then 0 and 1 held high must alternate.
    setVec(0, 4'b1000, 8'h00, 32'h0000_0033, 1, 3, 0, 0, 0);
    v = vecs[0];
    applyStimulus(v);
    waitDone("fair_pre");
    hold        = 4'b0011;
    in_port     = 32'h5A5A_0001;
    req_address = 8'h00;
    base        = cyc;
    for (int j = 0; j < 6; j++) begin
      pushExp(j % 2, 8'h00, 32'h5A5A_0001, base + 3 + 2 * j);
    end
    req = 4'b0011;
    n = 0;
    while (sb.size() > 2 && n < 40) begin
      step();
      n++;
    end
    hold = 4'b0000;
    waitDone("fair");

    // Reset while in WAIT discards the read.
    in_port     = 32'h0000_0077;
    req_address = 8'h00;
    req         = 4'b0001;
    step();
    checkOutput("midrst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    req   = 4'b0000;
    step();
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_gnt", 32'(gnt), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    step();
    step();
    step();
    setVec(0, 4'b0001, 8'h00, 32'h0000_0077, 1, 0, 0, 0, 0);
    v = vecs[0];
    applyStimulus(v);
    waitDone("midrst_fresh");

    // Same requester held across two reads: no chained self-grant.
    hold        = 4'b0001;
    in_port     = 32'h0BAD_F00D;
    req_address = 8'h00;
    base        = cyc;
    pushExp(0, 8'h00, 32'h0BAD_F00D, base + 3);
    pushExp(0, 8'h00, 32'h0BAD_F00D, base + 6);
    req = 4'b0001;
    n = 0;
    while (sb.size() > 1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
    checkOutput("b2b_idle_gnt", 32'(gnt), 32'd0);
    hold = 4'b0000;
    waitDone("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/systema_pio_read_arbiter.md
# systema_pio_read_arbiter

Round-robin read arbiter that shares one `systema` PIO input slave (2-bit address, 32-bit registered readdata) among several internal requesters. It sequences each access around the slave's one-cycle registered read latency, returns the captured word to the winning requester with a single-cycle valid pulse, and keeps grants fair. It sits between the requester logic and the PIO's `s1` slave port and is the only master driving that slave's `address`.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ADDR_W`, default 2: slave address width.
- `DATA_W`, default 32: slave readdata width.

**Ports**
- `clk`, input, 1: single clock; the slave runs on the same clock.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, NUM_REQ: level request per requester; held high until that requester's `rsp_valid`.
- `req_address`, input, NUM_REQ*ADDR_W: per-requester address; slice k is `[k*ADDR_W +: ADDR_W]`; stable while `req[k]` is high.
- `gnt`, output, NUM_REQ: one-hot grant of the current transaction owner.
- `rsp_valid`, output, NUM_REQ: one-cycle pulse to the owner when `rsp_data` is valid.
- `rsp_data`, output, DATA_W: captured slave word, shared by all requesters.
- `busy`, output, 1: high whenever the state is not IDLE.
- `slv_address`, output, ADDR_W: drives the slave address.
- `slv_readdata`, input, DATA_W: slave readdata, registered inside the slave.

## Operation

- **States**
  - IDLE: no owner.
  - WAIT: the address is presented and the slave registers its readdata.
  - CAP: the arbiter captures readdata.
- **Reset values:** state IDLE, `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `slv_address`=0, `busy`=0, round-robin pointer `ptr`=0.
- **Arbitration**
  - Search starts at index `ptr` and proceeds upward, wrapping modulo NUM_REQ.
  - The first index with its request high wins.
  - After granting k, `ptr` becomes (k+1) mod NUM_REQ; the value NUM_REQ-1 wraps to 0.
- **IDLE**
  - When any request is high: register the winner into `gnt`, load its `req_address` slice into `slv_address`, and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:** unconditionally go to CAP. `gnt` and `slv_address` are held.
- **CAP**
  - Load `rsp_data` from `slv_readdata` and pulse `rsp_valid` for the owner.
  - Arbitrate again over the requests with the current owner masked out, because its request is still high at this edge.
  - If there is a winner: grant it directly and go to WAIT (chained access).
  - Otherwise clear `gnt` and go to IDLE.
- **Data path rules**
  - `rsp_data` holds its value until the next capture.
  - Addresses are passed through unmodified. The slave returns 0 for any address other than 0, and the arbiter does no range checking.
- **Requester protocol**
  - A requester must sample `rsp_valid` and deassert `req` in that same cycle.
  - A request still high at the next arbitration edge counts as a new read.
  - Dropping `req` before `rsp_valid` is illegal. The transaction still completes and the pulse is still delivered.
- **Reset mid-transaction:** the cycle after the reset edge, every register holds its reset value. An in-flight read is discarded and no `rsp_valid` pulse is issued for it.

## Timing

- **Single read**
  - Edge E0: `req[k]` is seen in IDLE. From the cycle after E0, `gnt[k]`=1 and `slv_address` = address slice k.
  - Edge E1: the slave registers its readdata.
  - Edge E2: capture. In the cycle after E2, `rsp_valid[k]`=1 and `rsp_data` is valid.
  - Load-to-response latency is 3 edges.
- **Throughput**
  - Chained accesses complete one read every 2 cycles.
  - An isolated access occupies 3 cycles including the return to IDLE.
- **Simultaneous requests:** exactly one grant per arbitration edge. Losing requests stay pending with no timeout.
- **Fairness:** under full load, each requester receives a grant at most every NUM_REQ transactions.
- **Grant signal:** `gnt` is one-hot or zero in every cycle and never changes while in WAIT.

## Test plan

- **Single read:** set `in_port`=0xA5 on the slave, then pulse `req[2]` with address 0 from IDLE. Required: `rsp_valid[2]` high for exactly one cycle, 3 edges after the request; `rsp_data`=0x000000A5; `busy` low afterwards.
- **All requesters at once:** raise `req[3:0]`=4'b1111 from reset, each with address 0. Required: grants in order 0,1,2,3, one `rsp_valid` every 2 cycles; `ptr` returns to 0.
- **Wrap and fairness:** first complete a read by requester 3. Then hold `req[0]` and `req[1]` continuously, each re-raised after its response. Required: grants alternate 0,1,0,1 with no repeat of the same requester while the other is pending.
- **Non-zero address:** `req[1]` with address 2 while `in_port`=0xFF. Required: `rsp_data`=0x00000000.
- **Reset mid-flight:** assert `reset` for one cycle while in WAIT. Required: no `rsp_valid`, `gnt`=0, `busy`=0 the next cycle; a fresh `req[0]` then completes normally with a 3-edge latency.
- **Same requester back-to-back:** `req[0]` stays high across two reads. Required: after the first `rsp_valid[0]`, the state returns to IDLE with no chained grant to 0; the second response arrives 3 edges after the first.
